// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// reset_sequencer_pkg : state encoding, cause bit positions, width helper | rev 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

    localparam int CAUSE_BUTTON = 0;
    localparam int CAUSE_PLL    = 1;
    localparam int CAUSE_EXT    = 2;

    // Bits needed to hold every value in 0..max_value (never less than 1).
    function automatic int cnt_width(input int max_value);
        int w;
        w = 1;
        while ((1 << w) <= max_value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_debounce.sv
// ============================================================================
// reset_debounce : multi-stage synchroniser followed by a run-length debounce | rev 1.0
// ============================================================================
`default_nettype none

module reset_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 40000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int                 c_cnt_w = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_state;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign dout       = r_state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync  <= {SYNC_STAGES{RESET_VALUE}};
            r_cnt   <= '0;
            r_state <= RESET_VALUE;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            // Any sample matching the current state restarts the run.
            if (w_sync_out == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_state <= w_sync_out;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : button/PLL reset generator with ordered domain release | rev 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 40000,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_CYCLES    = 8,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   button_n,
    input  logic                   pll_locked,
    output logic [NUM_DOMAINS-1:0] reset_out,
    output logic                   ready,
    output logic [2:0]             cause,
    output logic [COUNT_WIDTH-1:0] reset_count
);

    localparam int c_hold_w  = cnt_width(HOLD_CYCLES);
    localparam int c_stage_w = cnt_width(STAGE_CYCLES - 1);
    localparam int c_cnt_w   = (c_hold_w > c_stage_w) ? c_hold_w : c_stage_w;

    // HOLD spans HOLD_CYCLES+1 edges, so the first release lands HOLD_CYCLES+1
    // edges after the ASSERT edge that first saw the fault clear.
    localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_stage_last = c_cnt_w'(STAGE_CYCLES - 1);
    localparam logic [2:0]         c_cause_ext  = 3'(1 << CAUSE_EXT);

    seq_state_t             r_state;
    logic [NUM_DOMAINS-1:0] r_rst;
    logic                   r_ready;
    logic [2:0]             r_cause;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [SYNC_STAGES-1:0] r_lock_sync;

    logic                   w_btn_deb;
    logic                   w_lock_s;
    logic                   w_fault;
    logic [2:0]             w_fault_cause;
    logic [NUM_DOMAINS-1:0] w_rst_next;
    logic                   w_last;

    reset_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (1'b1)
    ) u_btn_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (button_n),
        .dout    (w_btn_deb)
    );

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_fault  = ~w_btn_deb | ~w_lock_s;

    // Released domains are the low zeros of r_rst; shifting left frees the next one.
    assign w_rst_next = r_rst << 1;
    assign w_last     = (w_rst_next == '0);

    always_comb begin
        w_fault_cause               = '0;
        w_fault_cause[CAUSE_BUTTON] = ~w_btn_deb;
        w_fault_cause[CAUSE_PLL]    = ~w_lock_s;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ASSERT;
            r_rst       <= '1;
            r_ready     <= 1'b0;
            r_cause     <= c_cause_ext;
            r_count     <= '0;
            r_cnt       <= '0;
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
            if (w_fault) begin
                // Only a fault that interrupts a released/holding system is recorded.
                if (r_state != ASSERT) begin
                    r_cause <= w_fault_cause;
                    if (r_count != '1) begin
                        r_count <= r_count + COUNT_WIDTH'(1);
                    end
                end
                r_state <= ASSERT;
                r_rst   <= '1;
                r_ready <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ASSERT: begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end
                    HOLD: begin
                        if (r_cnt == c_hold_last) begin
                            r_rst   <= w_rst_next;
                            r_cnt   <= '0;
                            r_state <= w_last ? RUN : RELEASE;
                            r_ready <= w_last;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                    RELEASE: begin
                        if (r_cnt == c_stage_last) begin
                            r_rst   <= w_rst_next;
                            r_cnt   <= '0;
                            r_state <= w_last ? RUN : RELEASE;
                            r_ready <= w_last;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                    RUN: begin
                        r_rst   <= '0;
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= ASSERT;
                        r_rst   <= '1;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reset_out   = r_rst;
    assign ready       = r_ready;
    assign cause       = r_cause;
    assign reset_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer : scoreboard bench, two parameter sets, behavioural model | rev 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DEB  = 8;

    typedef struct {
        int          cyc;
        logic [15:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n, button_n, pll_locked;

    logic [3:0] ro0;
    logic       rdy0;
    logic [2:0] cause0;
    logic [7:0] cnt0;
    logic [0:0] ro1;
    logic       rdy1;
    logic [2:0] cause1;
    logic [7:0] cnt1;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(16), .STAGE_CYCLES(8), .COUNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .button_n(button_n), .pll_locked(pll_locked),
        .reset_out(ro0), .ready(rdy0), .cause(cause0), .reset_count(cnt0)
    );

    reset_sequencer #(
        .NUM_DOMAINS(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(1), .STAGE_CYCLES(1), .COUNT_WIDTH(8)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .button_n(button_n), .pll_locked(pll_locked),
        .reset_out(ro1), .ready(rdy1), .cause(cause1), .reset_count(cnt1)
    );

    int nd_p    [2] = '{4, 1};
    int hold_p  [2] = '{16, 1};
    int stage_p [2] = '{8, 1};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ev_t q0[$];
    ev_t q1[$];

    // Reference model: delay lines, run-length debounce, and "edges since fault clear".
    bit [SYNC-1:0] lock_hist [2];
    bit [SYNC-1:0] btn_hist  [2];
    bit            deb       [2];
    int            diff      [2];
    int            run       [2];
    bit [2:0]      m_cause   [2];
    int            m_cnt     [2];
    logic [15:0]   m_prev    [2] = '{16'hxxxx, 16'hxxxx};

    initial begin
        ev_t         ev;
        logic [15:0] e;
        logic [3:0]  ro;
        bit          ls, bs, f;
        int          rel, mask, relm;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (!reset_n) begin
                    lock_hist[d] = '0;
                    btn_hist[d]  = '1;
                    deb[d]       = 1'b1;
                    diff[d]      = 0;
                    run[d]       = 0;
                    m_cause[d]   = 3'b100;
                    m_cnt[d]     = 0;
                end else begin
                    ls = lock_hist[d][SYNC-1];
                    bs = btn_hist[d][SYNC-1];
                    f  = !deb[d] || !ls;
                    if (f) begin
                        if (run[d] > 0) begin
                            m_cause[d] = {1'b0, !ls, !deb[d]};
                            if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
                        end
                        run[d] = 0;
                    end else if (run[d] < 1000000) begin
                        run[d] = run[d] + 1;
                    end
                    if (bs != deb[d]) begin
                        diff[d] = diff[d] + 1;
                        if (diff[d] == DEB) begin
                            deb[d]  = bs;
                            diff[d] = 0;
                        end
                    end else begin
                        diff[d] = 0;
                    end
                    lock_hist[d] = {lock_hist[d][SYNC-2:0], pll_locked};
                    btn_hist[d]  = {btn_hist[d][SYNC-2:0], button_n};
                end
                // Domain k is free once HOLD+2+k*STAGE consecutive clear samples are seen.
                rel = 0;
                if (run[d] >= hold_p[d] + 2) rel = 1 + (run[d] - hold_p[d] - 2) / stage_p[d];
                if (rel > nd_p[d]) rel = nd_p[d];
                mask = (1 << nd_p[d]) - 1;
                relm = (1 << rel) - 1;
                ro   = 4'(mask & ~relm);
                e    = {ro, (rel == nd_p[d]), m_cause[d], 8'(m_cnt[d])};
                if (e !== m_prev[d]) begin
                    ev.cyc = cyc;
                    ev.v   = e;
                    if (d == 0) q0.push_back(ev);
                    else        q1.push_back(ev);
                end
                m_prev[d] = e;
            end
        end
    end

    logic [15:0] mon_last [2] = '{16'hxxxx, 16'hxxxx};

    initial begin
        logic [15:0] a;
        ev_t         ev;
        int          qs;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                a  = (d == 0) ? {ro0, rdy0, cause0, cnt0} : {3'b000, ro1, rdy1, cause1, cnt1};
                qs = (d == 0) ? q0.size() : q1.size();
                if (a !== mon_last[d]) begin
                    checks = checks + 1;
                    if (qs == 0) begin
                        errors = errors + 1;
                        $display("FAIL dut%0d unexpected_change cyc=%0d got=%h", d, cyc, a);
                    end else begin
                        ev = (d == 0) ? q0.pop_front() : q1.pop_front();
                        if (ev.cyc != cyc || ev.v !== a) begin
                            errors = errors + 1;
                            $display("FAIL dut%0d event cyc=%0d got=%h exp=%h exp_cyc=%0d",
                                     d, cyc, a, ev.v, ev.cyc);
                        end
                    end
                    mon_last[d] = a;
                end else if (qs > 0) begin
                    ev = (d == 0) ? q0[0] : q1[0];
                    if (ev.cyc <= cyc) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL dut%0d missing_change cyc=%0d got=%h exp=%h", d, cyc, a, ev.v);
                        if (d == 0) void'(q0.pop_front());
                        else        void'(q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic pll_pulse(input int len);
        pll_locked = 1'b0;
        repeat (len) @(negedge clk);
        pll_locked = 1'b1;
    endtask

    task automatic button_pulse(input int len);
        button_n = 1'b0;
        repeat (len) @(negedge clk);
        button_n = 1'b1;
    endtask

    initial begin
        int k;
        reset_n    = 1'b0;
        button_n   = 1'b1;
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);

        pll_pulse(1);
        repeat (60) @(negedge clk);

        button_pulse(5);
        repeat (30) @(negedge clk);

        button_pulse(20);
        repeat (70) @(negedge clk);

        // Interrupt the release sequence half way through.
        pll_pulse(1);
        for (int i = 0; i < 200 && ro0 != 4'b1100; i++) @(negedge clk);
        pll_pulse(1);
        repeat (60) @(negedge clk);

        // Master reset while both instances sit in HOLD.
        pll_pulse(1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);

        repeat (40) begin
            k = int'($urandom_range(0, 2));
            if (k == 0)      pll_pulse(int'($urandom_range(1, 3)));
            else if (k == 1) button_pulse(int'($urandom_range(1, 20)));
            repeat ($urandom_range(1, 80)) @(negedge clk);
        end

        repeat (260) begin
            pll_pulse(1);
            repeat (6) @(negedge clk);
        end
        checks = checks + 1;
        if (cnt0 !== 8'hff) begin
            errors = errors + 1;
            $display("FAIL saturation reset_count got=%h exp=ff", cnt0);
        end

        repeat (80) @(negedge clk);
        checks = checks + 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending q0=%0d q1=%0d exp=0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
